// File: rtl/secuenciador_selec_ddw.sv
// Slot sequencer for the RTC data-block decoder: walks the init, read and write
// register slots and hands each one to the bus driver under a per-slot timeout.
module secuenciador_selec_ddw #(
   parameter int N_REFRESCO = 1000,
   parameter int T_ESPERA   = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       escribir,
   input  logic       fin_trans,
   output logic [3:0] Selec_Mux_DDw,
   output logic       inicio_trans,
   output logic       escritura,
   output logic       ocupado,
   output logic       fin_ciclo,
   output logic       error_to
);
   localparam int RW = $clog2(N_REFRESCO);
   localparam int EW = $clog2(T_ESPERA);
   localparam logic [RW-1:0] REF_FIN = RW'(N_REFRESCO - 1);
   localparam logic [RW-1:0] REF_UNO = RW'(1);
   localparam logic [EW-1:0] ESP_FIN = EW'(T_ESPERA - 1);
   localparam logic [EW-1:0] ESP_UNO = EW'(1);
   localparam logic [3:0] SEL_NINGUNO = 4'b1111;
   localparam logic [3:0] SEL_INIT    = 4'b0000;
   localparam logic [3:0] SEL_MODO    = 4'b0001;
   localparam logic [3:0] SEL_CMD     = 4'b0010;
   localparam logic [3:0] SEL_ULTIMO  = 4'b1000;

   typedef enum logic [1:0] {
      INI    = 2'd0,
      ESPERA = 2'd1,
      FIN    = 2'd2,
      REPOSO = 2'd3
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [3:0]    selec_q, selec_d;
   logic          inicio_q, inicio_d;
   logic          escr_q, escr_d;
   logic          ocup_q, ocup_d;
   logic          fin_q, fin_d;
   logic          err_q, err_d;
   logic          pend_q, pend_d;
   logic [RW-1:0] ref_q, ref_d;
   logic [EW-1:0] esp_q, esp_d;
   logic          ultimo_s;
   logic          en_init_s;

   // The slot code itself tells which sequence is running and where it ends.
   assign ultimo_s  = (selec_q == SEL_MODO) || (selec_q == SEL_ULTIMO);
   assign en_init_s = (selec_q == SEL_INIT) || (selec_q == SEL_MODO);

   always_comb begin
      estado_d = estado_q;
      selec_d  = selec_q;
      inicio_d = 1'b0;
      escr_d   = escr_q;
      ocup_d   = ocup_q;
      fin_d    = 1'b0;
      err_d    = 1'b0;
      pend_d   = pend_q | escribir;
      ref_d    = '0;
      esp_d    = esp_q;
      case (estado_q)
         INI: begin
            estado_d = ESPERA;
            selec_d  = SEL_INIT;
            escr_d   = 1'b1;
            ocup_d   = 1'b1;
            inicio_d = 1'b1;
            esp_d    = '0;
         end
         ESPERA: begin
            if (fin_trans) begin
               esp_d = '0;
               if (ultimo_s) begin
                  estado_d = FIN;
                  selec_d  = SEL_NINGUNO;
                  escr_d   = 1'b0;
                  ocup_d   = 1'b0;
                  fin_d    = 1'b1;
               end else begin
                  selec_d  = selec_q + 4'd1;
                  inicio_d = 1'b1;
               end
            end else if (esp_q == ESP_FIN) begin
               // An init abort must retry from slot 0000 rather than idle.
               estado_d = en_init_s ? INI : REPOSO;
               selec_d  = SEL_NINGUNO;
               escr_d   = 1'b0;
               ocup_d   = 1'b0;
               err_d    = 1'b1;
               esp_d    = '0;
            end else begin
               esp_d = esp_q + ESP_UNO;
            end
         end
         FIN: begin
            estado_d = REPOSO;
         end
         REPOSO: begin
            if (pend_q) begin
               estado_d = ESPERA;
               selec_d  = SEL_CMD;
               escr_d   = 1'b1;
               ocup_d   = 1'b1;
               inicio_d = 1'b1;
               esp_d    = '0;
               pend_d   = 1'b0;
            end else if (ref_q == REF_FIN) begin
               estado_d = ESPERA;
               selec_d  = SEL_CMD;
               escr_d   = 1'b0;
               ocup_d   = 1'b1;
               inicio_d = 1'b1;
               esp_d    = '0;
            end else begin
               ref_d = ref_q + REF_UNO;
            end
         end
         default: begin
            estado_d = INI;
            selec_d  = SEL_NINGUNO;
            escr_d   = 1'b0;
            ocup_d   = 1'b0;
            esp_d    = '0;
         end
      endcase
   end

   // State, counters and every output are registered together.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= INI;
         selec_q  <= SEL_NINGUNO;
         inicio_q <= 1'b0;
         escr_q   <= 1'b0;
         ocup_q   <= 1'b0;
         fin_q    <= 1'b0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
         ref_q    <= '0;
         esp_q    <= '0;
      end else begin
         estado_q <= estado_d;
         selec_q  <= selec_d;
         inicio_q <= inicio_d;
         escr_q   <= escr_d;
         ocup_q   <= ocup_d;
         fin_q    <= fin_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
         ref_q    <= ref_d;
         esp_q    <= esp_d;
      end
   end

   assign Selec_Mux_DDw = selec_q;
   assign inicio_trans  = inicio_q;
   assign escritura     = escr_q;
   assign ocupado       = ocup_q;
   assign fin_ciclo     = fin_q;
   assign error_to      = err_q;
endmodule

// File: tb/tb_secuenciador_selec_ddw.sv
// Bench for secuenciador_selec_ddw: reset/init vector table, hand-written
// corner-case sequences, then random traffic against a transaction-level model.
module tb_secuenciador_selec_ddw;
   localparam int NR = 20;
   localparam int TE = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       escribir = 1'b0;
   logic       fin_trans = 1'b0;
   logic [3:0] sel;
   logic       ini, wr, busy, done, err;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   secuenciador_selec_ddw #(.N_REFRESCO(NR), .T_ESPERA(TE)) dut (
      .clk          (clk),
      .reset        (reset),
      .escribir     (escribir),
      .fin_trans    (fin_trans),
      .Selec_Mux_DDw(sel),
      .inicio_trans (ini),
      .escritura    (wr),
      .ocupado      (busy),
      .fin_ciclo    (done),
      .error_to     (err)
   );

   always #5 clk = ~clk;

   // Reference model: the visible outputs plus the list of slots still to run.
   logic [3:0] m_sel = 4'hF;
   logic       m_start = 1'b0, m_wr = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
   logic [3:0] m_rest[$];
   logic       m_init_seq = 1'b0, m_need_init = 1'b1, m_after_done = 1'b0, m_pend = 1'b0;
   int         m_age = 0, m_idle = 0;

   task automatic m_begin(input int first, input int last, input logic w);
      m_rest.delete();
      for (int c = first + 1; c <= last; c++) m_rest.push_back(4'(c));
      m_sel      = 4'(first);
      m_start    = 1'b1;
      m_busy     = 1'b1;
      m_wr       = w;
      m_age      = 0;
      m_idle     = 0;
      m_init_seq = (first == 0);
   endtask

   task automatic m_step(input logic r, input logic e, input logic f);
      logic pend_next;
      m_start = 1'b0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      if (r) begin
         m_sel = 4'hF; m_wr = 1'b0; m_busy = 1'b0; m_rest.delete();
         m_need_init = 1'b1; m_after_done = 1'b0; m_pend = 1'b0;
         m_idle = 0; m_age = 0;
      end else begin
         pend_next = m_pend | e;
         if (m_need_init) begin
            m_need_init = 1'b0;
            m_begin(0, 1, 1'b1);
         end else if (m_busy) begin
            if (f) begin
               if (m_rest.size() == 0) begin
                  m_sel = 4'hF; m_busy = 1'b0; m_wr = 1'b0;
                  m_done = 1'b1; m_after_done = 1'b1;
               end else begin
                  m_sel = m_rest.pop_front();
                  m_start = 1'b1;
                  m_age = 0;
               end
            end else if (m_age == TE - 1) begin
               m_sel = 4'hF; m_busy = 1'b0; m_wr = 1'b0; m_err = 1'b1; m_idle = 0;
               if (m_init_seq) m_need_init = 1'b1;
            end else begin
               m_age++;
            end
         end else if (m_after_done) begin
            m_after_done = 1'b0;
            m_idle = 0;
         end else if (m_pend) begin
            m_begin(2, 8, 1'b1);
            pend_next = 1'b0;
         end else if (m_idle == NR - 1) begin
            m_begin(2, 8, 1'b0);
         end else begin
            m_idle++;
         end
         m_pend = pend_next;
      end
   endtask

   function automatic logic [8:0] outs();
      return {sel, ini, wr, busy, done, err};
   endfunction

   task automatic step(input logic r, input logic e, input logic f);
      logic [8:0] got, exp;
      reset = r; escribir = e; fin_trans = f;
      @(posedge clk);
      m_step(r, e, f);
      #1;
      cyc++;
      got = outs();
      exp = {m_sel, m_start, m_wr, m_busy, m_done, m_err};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL model cyc=%0d: got sel=%b ini/wr/busy/done/err=%b, expected sel=%b %b",
                  cyc, got[8:5], got[4:0], exp[8:5], exp[4:0]);
      end
   endtask

   task automatic chk(input string name, input logic [8:0] exp);
      logic [8:0] got;
      got = outs();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d: got sel=%b ini/wr/busy/done/err=%b, expected sel=%b %b",
                  name, cyc, got[8:5], got[4:0], exp[8:5], exp[4:0]);
      end
   endtask

   task automatic chk_n(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Fin_trans d cycles after the slot's inicio_trans cycle (d=0: same cycle).
   task automatic serve(input int d);
      repeat (d) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
   endtask

   // Steps with quiet inputs until inicio_trans appears; returns idle cycles seen.
   task automatic count_idle(input int already, output int n);
      n = already;
      for (int k = 0; k < 40 && !ini; k++) begin
         step(1'b0, 1'b0, 1'b0);
         if (!ini) n++;
      end
   endtask

   typedef struct packed {
      logic       r;
      logic       e;
      logic       f;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[13];
   int   n;
   logic rr, ee, ff;
   int   cd, pick;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, {4'hF, 5'b00000}};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, {4'hF, 5'b00000}};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, {4'h0, 5'b11100}};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, {4'h1, 5'b11100}};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, {4'h1, 5'b01100}};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, {4'h1, 5'b01100}};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, {4'hF, 5'b00010}};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, {4'hF, 5'b00000}};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, {4'hF, 5'b00000}};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, {4'hF, 5'b00000}};
      tbl[10] = '{1'b0, 1'b0, 1'b0, {4'h2, 5'b11100}};
      tbl[11] = '{1'b0, 1'b0, 1'b1, {4'h3, 5'b11100}};
      tbl[12] = '{1'b0, 1'b0, 1'b0, {4'h3, 5'b01100}};
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].f);
         chk($sformatf("tbl%0d", i), tbl[i].exp);
      end

      // Init with fin_trans three cycles after each inicio_trans.
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("A_init0", {4'h0, 5'b11100});
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("A_hold0", {4'h0, 5'b01100});
      step(1'b0, 1'b0, 1'b1);
      chk("A_init1", {4'h1, 5'b11100});
      serve(3);
      chk("A_fin", {4'hF, 5'b00010});

      // Refresh: exactly NR idle cycles, then seven read slots.
      count_idle(0, n);
      chk_n("B_idle", n, NR);
      chk("B_read0", {4'h2, 5'b10100});
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 1'b1);
         chk($sformatf("B_slot%0d", k + 3), {4'(3 + k), 5'b10100});
      end
      step(1'b0, 1'b0, 1'b1);
      chk("B_fin", {4'hF, 5'b00010});

      // Two escribir pulses during a read: read unchanged, one write after.
      count_idle(0, n);
      chk_n("C_idle", n, NR);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      chk("C_esc_at4", {4'h4, 5'b00100});
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("C_unchanged", {4'h6, 5'b10100});
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("C_fin", {4'hF, 5'b00010});
      step(1'b0, 1'b0, 1'b0);
      chk("C_repo1", {4'hF, 5'b00000});
      step(1'b0, 1'b0, 1'b0);
      chk("C_write", {4'h2, 5'b11100});
      repeat (6) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("C_wfin", {4'hF, 5'b00010});
      count_idle(0, n);
      chk_n("C_idle2", n, NR);
      chk("C_read_not_write", {4'h2, 5'b10100});

      // Timeout at slot 0110, refresh restarts from zero.
      repeat (4) step(1'b0, 1'b0, 1'b1);
      chk("D_at6", {4'h6, 5'b10100});
      repeat (TE - 1) step(1'b0, 1'b0, 1'b0);
      chk("D_hold", {4'h6, 5'b00100});
      step(1'b0, 1'b0, 1'b0);
      chk("D_err", {4'hF, 5'b00001});
      count_idle(1, n);
      chk_n("D_idle", n, NR);

      // Timeout during init retries 0000.
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("E_init0", {4'h0, 5'b11100});
      repeat (TE - 1) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("E_err", {4'hF, 5'b00001});
      step(1'b0, 1'b0, 1'b0);
      chk("E_retry", {4'h0, 5'b11100});

      // Reset while slot 0101 is active.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("F_write", {4'h2, 5'b11100});
      repeat (3) step(1'b0, 1'b0, 1'b1);
      chk("F_at5", {4'h5, 5'b11100});
      step(1'b1, 1'b0, 1'b0);
      chk("F_reset", {4'hF, 5'b00000});
      step(1'b0, 1'b0, 1'b0);
      chk("F_restart", {4'h0, 5'b11100});

      // Random traffic: responder delays, spurious idle fin_trans, timeouts, resets.
      step(1'b1, 1'b0, 1'b0);
      cd = -1;
      for (int k = 0; k < 3000; k++) begin
         ee = ($urandom_range(0, 29) == 0);
         if (m_start) begin
            pick = $urandom_range(0, 9);
            cd = (pick < 8) ? $urandom_range(0, 3) : TE + 4;
         end
         ff = 1'b0;
         if (m_busy) begin
            ff = (cd == 0);
            if (cd >= 0) cd--;
         end else begin
            ff = ($urandom_range(0, 7) == 0);
         end
         rr = ($urandom_range(0, 499) == 0);
         step(rr, ee, ff);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
